// File: rtl/seq_arbiter.sv
// Two-requester round-robin scheduler for a shared 2-bit, 4-step pattern sequencer.
// Optional input debouncing is enabled by defining BTN_DEBOUNCE_EN.
module seq_arbiter #(
  parameter int DIV_W     = 24,
  parameter int DEB_TICKS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn1,
  input  logic       btn2,
  output logic [1:0] outputs,
  output logic [1:0] grant,
  output logic       busy,
  output logic       done,
  output logic       tick
);

  typedef enum logic [1:0] {IDLE, S1, S2, S3} state_t;

  localparam logic [DIV_W-1:0] ONES = '1;

  state_t           state, state_next;
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       sync_a, sync_b, level, level_d, rise;
  logic [1:0]       pend, pend_next, clr;
  logic             last_grant, last_next, win;
  logic [1:0]       outputs_next, grant_next;
  logic             busy_next, done_next;

  // Step pattern for a given owner (0 = btn1, 1 = btn2) and step 1..3.
  function automatic logic [1:0] pattern(input logic owner, input logic [1:0] step);
    case (step)
      2'd1:    pattern = owner ? 2'b01 : 2'b10;
      2'd2:    pattern = owner ? 2'b10 : 2'b01;
      2'd3:    pattern = 2'b11;
      default: pattern = 2'b00;
    endcase
  endfunction

  // Prescaler: tick is registered so it is high while div_cnt is all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      tick    <= (div_cnt == ONES - 1'b1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_a  <= '0;
      sync_b  <= '0;
      level_d <= '0;
    end else begin
      sync_a  <= {btn2, btn1};
      sync_b  <= sync_a;
      level_d <= level;
    end
  end

`ifdef BTN_DEBOUNCE_EN
  localparam int CW = $clog2(DEB_TICKS + 1);

  logic [1:0]    deb;
  logic [CW-1:0] deb_cnt [2];

  // Level follows the synchronised input only after DEB_TICKS consecutive differing ticks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb        <= '0;
      deb_cnt[0] <= '0;
      deb_cnt[1] <= '0;
    end else if (tick) begin
      for (int i = 0; i < 2; i++) begin
        if (sync_b[i] != deb[i]) begin
          if (deb_cnt[i] == CW'(DEB_TICKS - 1)) begin
            deb[i]     <= sync_b[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  assign level = deb;
`else
  logic unused_deb;
  assign unused_deb = ^DEB_TICKS;
  assign level      = sync_b;
`endif

  assign rise = level & ~level_d;

  always_comb begin
    state_next   = state;
    outputs_next = outputs;
    grant_next   = grant;
    busy_next    = busy;
    done_next    = 1'b0;
    last_next    = last_grant;
    clr          = 2'b00;
    win          = 1'b0;
    if (tick) begin
      case (state)
        IDLE: begin
          if (pend != 2'b00) begin
            win          = (pend == 2'b11) ? ~last_grant : pend[1];
            clr          = win ? 2'b10 : 2'b01;
            grant_next   = clr;
            last_next    = win;
            outputs_next = pattern(win, 2'd1);
            busy_next    = 1'b1;
            state_next   = S1;
          end
        end
        S1: begin
          outputs_next = pattern(grant[1], 2'd2);
          state_next   = S2;
        end
        S2: begin
          outputs_next = pattern(grant[1], 2'd3);
          state_next   = S3;
        end
        default: begin
          outputs_next = 2'b00;
          grant_next   = 2'b00;
          busy_next    = 1'b0;
          done_next    = 1'b1;
          state_next   = IDLE;
        end
      endcase
    end
    // A fresh edge in the grant cycle keeps the request queued.
    pend_next = (pend & ~clr) | rise;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      pend       <= '0;
      last_grant <= 1'b1;
      outputs    <= '0;
      grant      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      pend       <= pend_next;
      last_grant <= last_next;
      outputs    <= outputs_next;
      grant      <= grant_next;
      busy       <= busy_next;
      done       <= done_next;
    end
  end

endmodule
